// File: rtl/rv32_id_ex_stage.sv
// ---------------------------------------------------------------------------
// rv32_id_ex_stage
//   ID/EX pipeline register for a 5-stage RV32 integer pipeline.
//   Captures the decoded instruction, bypasses the register-file writeback
//   into the captured operands, detects load-use hazards against the
//   instruction held in the stage, and inserts one-cycle bubbles.
//
// Ports
//   mp_clk_in, mp_rst_in         clock, asynchronous active-high reset
//   valid_in/stall_in/flush_in   decode valid, downstream hold, stage kill
//   pc_in, rs_*_addr_in, rd_addr_in, rs_*_in, imm_in, alu_op_in,
//   wr_eb_in, load_in            decoded instruction fields
//   wb_rd_addr_in/wb_wr_eb_in/wb_rd_in   register-file writeback port
//   *_out                        registered copies of the instruction fields
//   hazard_stall_out             combinational load-use hold to decode
//   bubble_cnt_out               saturating count of bubbles inserted
// ---------------------------------------------------------------------------
module rv32_id_ex_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             mp_clk_in,
  input  logic             mp_rst_in,
  input  logic             valid_in,
  input  logic             stall_in,
  input  logic             flush_in,
  input  logic [31:0]      pc_in,
  input  logic [4:0]       rs_1_addr_in,
  input  logic [4:0]       rs_2_addr_in,
  input  logic [4:0]       rd_addr_in,
  input  logic [31:0]      rs_1_in,
  input  logic [31:0]      rs_2_in,
  input  logic [31:0]      imm_in,
  input  logic [3:0]       alu_op_in,
  input  logic             wr_eb_in,
  input  logic             load_in,
  input  logic [4:0]       wb_rd_addr_in,
  input  logic             wb_wr_eb_in,
  input  logic [31:0]      wb_rd_in,
  output logic             valid_out,
  output logic [31:0]      pc_out,
  output logic [31:0]      rs_1_out,
  output logic [31:0]      rs_2_out,
  output logic [4:0]       rs_1_addr_out,
  output logic [4:0]       rs_2_addr_out,
  output logic [4:0]       rd_addr_out,
  output logic [31:0]      imm_out,
  output logic [3:0]       alu_op_out,
  output logic             wr_eb_out,
  output logic             load_out,
  output logic             hazard_stall_out,
  output logic [CNT_W-1:0] bubble_cnt_out
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned OPW  = 4;

  // Stage payload held between ID and EX
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs_1;
    logic [XLEN-1:0] rs_2;
    logic [RW-1:0]   rs_1_addr;
    logic [RW-1:0]   rs_2_addr;
    logic [RW-1:0]   rd_addr;
    logic [XLEN-1:0] imm;
    logic [OPW-1:0]  alu_op;
    logic            wr_eb;
    logic            load;
  } stage_t;

  stage_t           stage_q;
  stage_t           stage_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             hazard;
  logic             bump;
  logic             wb_hit_held_1;
  logic             wb_hit_held_2;

  // Operand select: x0 reads zero, a same-cycle writeback wins over stale data
  function automatic logic [XLEN-1:0] pick_operand(
    input logic [RW-1:0]   src,
    input logic [XLEN-1:0] data,
    input logic            wb_en,
    input logic [RW-1:0]   wb_addr,
    input logic [XLEN-1:0] wb_data
  );
    logic [XLEN-1:0] res;
    res = data;
    if (src == RW'(0)) begin
      res = XLEN'(0);
    end else if (wb_en && (wb_addr == src)) begin
      res = wb_data;
    end
    return res;
  endfunction

  // Load-use hazard: held load writes a register the decode instruction reads
  always_comb begin
    hazard = stage_q.valid && stage_q.load && (stage_q.rd_addr != RW'(0)) &&
             valid_in &&
             ((rs_1_addr_in == stage_q.rd_addr) || (rs_2_addr_in == stage_q.rd_addr));
  end

  assign hazard_stall_out = hazard;

  // Writeback hits on the held operands (only x1..x31 can be written)
  always_comb begin
    wb_hit_held_1 = wb_wr_eb_in && (wb_rd_addr_in != RW'(0)) &&
                    (wb_rd_addr_in == stage_q.rs_1_addr);
    wb_hit_held_2 = wb_wr_eb_in && (wb_rd_addr_in != RW'(0)) &&
                    (wb_rd_addr_in == stage_q.rs_2_addr);
  end

  // Next stage contents: flush > stall > hazard bubble > normal capture
  always_comb begin
    stage_d = stage_q;
    bump    = 1'b0;
    if (flush_in) begin
      stage_d = '0;
      // Only killing a live instruction costs a slot; a coincident hazard is
      // covered by this same increment.
      bump    = stage_q.valid;
    end else if (stall_in) begin
      if (wb_hit_held_1) begin
        stage_d.rs_1 = wb_rd_in;
      end
      if (wb_hit_held_2) begin
        stage_d.rs_2 = wb_rd_in;
      end
    end else if (hazard) begin
      // Bubble leaves valid_out low, so the hazard cannot repeat next cycle
      stage_d = '0;
      bump    = 1'b1;
    end else begin
      stage_d.valid     = valid_in;
      stage_d.pc        = pc_in;
      stage_d.rs_1_addr = rs_1_addr_in;
      stage_d.rs_2_addr = rs_2_addr_in;
      stage_d.rd_addr   = rd_addr_in;
      stage_d.imm       = imm_in;
      stage_d.alu_op    = alu_op_in;
      stage_d.wr_eb     = valid_in && wr_eb_in;
      stage_d.load      = valid_in && load_in;
      stage_d.rs_1      = pick_operand(rs_1_addr_in, rs_1_in, wb_wr_eb_in,
                                       wb_rd_addr_in, wb_rd_in);
      stage_d.rs_2      = pick_operand(rs_2_addr_in, rs_2_in, wb_wr_eb_in,
                                       wb_rd_addr_in, wb_rd_in);
    end
  end

  // Saturating bubble counter
  always_comb begin
    cnt_d = cnt_q;
    if (bump && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Stage and counter registers
  always_ff @(posedge mp_clk_in or posedge mp_rst_in) begin
    if (mp_rst_in) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_out      = stage_q.valid;
  assign pc_out         = stage_q.pc;
  assign rs_1_out       = stage_q.rs_1;
  assign rs_2_out       = stage_q.rs_2;
  assign rs_1_addr_out  = stage_q.rs_1_addr;
  assign rs_2_addr_out  = stage_q.rs_2_addr;
  assign rd_addr_out    = stage_q.rd_addr;
  assign imm_out        = stage_q.imm;
  assign alu_op_out     = stage_q.alu_op;
  assign wr_eb_out      = stage_q.wr_eb;
  assign load_out       = stage_q.load;
  assign bubble_cnt_out = cnt_q;

endmodule
